// File: rtl/lane_word_arbiter_pkg.sv
// Shared types and helpers for the lane word arbiter.
// Optional feature macro: ARB_TIMEOUT_EN (adds the PAD state and its fill byte).
package lane_word_arbiter_pkg;

`ifdef ARB_TIMEOUT_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    PAD   = 2'd2
  } arb_state_t;

  localparam logic [7:0] DEF_PAD_BYTE = 8'hBC;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1
  } arb_state_t;
`endif

  // Width of a lane index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lane_word_arbiter_if.sv
// Bus between the byte lanes, the arbiter and the downstream word packer.
// The slave modport is the arbiter's view; master is the lanes/packer side.
interface lane_word_arbiter_if
  import lane_word_arbiter_pkg::*;
#(
  parameter int N_LANES = 4
) ();

  localparam int IDXW = idx_width(N_LANES);

  logic [N_LANES-1:0]   valid_lane;
  logic [8*N_LANES-1:0] data_lane;
  logic [N_LANES-1:0]   ready_lane;
  logic                 valid_out;
  logic [7:0]           Data_out;
  logic [IDXW-1:0]      lane_out;
  logic                 sow_out;
  logic                 busy;

  modport master (
    output valid_lane, data_lane,
    input  ready_lane, valid_out, Data_out, lane_out, sow_out, busy
  );

  modport slave (
    input  valid_lane, data_lane,
    output ready_lane, valid_out, Data_out, lane_out, sow_out, busy
  );

endinterface

// File: rtl/lane_word_arbiter_rr_priority_sel.sv
// Round-robin pick: the first requesting lane after 'last', wrapping around.
// 'last' itself is only chosen when it is the sole requester.
module rr_priority_sel
  import lane_word_arbiter_pkg::*;
#(
  parameter int N    = 4,
  parameter int IDXW = idx_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] last,
  output logic [IDXW-1:0] gnt_idx,
  output logic            any_req
);

  int cand;

  // Scan from farthest to nearest so the nearest requester after 'last' wins.
  always_comb begin
    gnt_idx = '0;
    cand    = 0;
    for (int k = N; k >= 1; k--) begin
      cand = (int'(last) + k) % N;
      if (req[cand]) gnt_idx = IDXW'(cand);
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/lane_word_arbiter.sv
// Round-robin arbiter granting one byte lane per whole packer word.
// Outputs are registered (one cycle after the accepting handshake).
// Optional feature macro: ARB_TIMEOUT_EN pads a stalled word with PAD_BYTE.
module lane_word_arbiter
  import lane_word_arbiter_pkg::*;
#(
  parameter int N_LANES    = 4,
  parameter int WORD_BYTES = 4
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int         TIMEOUT  = 8,
  parameter logic [7:0] PAD_BYTE = DEF_PAD_BYTE
`endif
) (
  input logic                 clk_4f,
  input logic                 reset,
  lane_word_arbiter_if.slave  bus
);

  localparam int IDXW = idx_width(N_LANES);
  localparam int CW   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [CW-1:0]      LAST_BYTE = CW'(WORD_BYTES - 1);
  localparam logic [N_LANES-1:0] LANE0_HOT = N_LANES'(1);
`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] STALL_LIMIT = TW'(TIMEOUT - 1);
`endif

  arb_state_t      state, state_next;
  logic [IDXW-1:0] grant, grant_next;
  logic [IDXW-1:0] rr_last, rr_last_next;
  logic [IDXW-1:0] sel_last, gnt_idx;
  logic [IDXW-1:0] lane_q, lane_next;
  logic [CW-1:0]   byte_cnt, cnt_next;
  logic [7:0]      dout_q, dout_next, grant_byte;
  logic            vout_q, vout_next;
  logic            sow_q, sow_next;
  logic            any_req, emit;
`ifdef ARB_TIMEOUT_EN
  logic [TW-1:0]   stall_cnt, stall_next;
`endif

  // In IDLE the pointer is the last finished word; at a word end it is the current grant.
  assign sel_last   = (state == IDLE) ? rr_last : grant;
  assign grant_byte = bus.data_lane[8*int'(grant) +: 8];

  rr_priority_sel #(
    .N    (N_LANES),
    .IDXW (IDXW)
  ) u_sel (
    .req     (bus.valid_lane),
    .last    (sel_last),
    .gnt_idx (gnt_idx),
    .any_req (any_req)
  );

  // Next-state, grant, byte counter and output-register values.
  always_comb begin
    state_next   = state;
    grant_next   = grant;
    rr_last_next = rr_last;
    cnt_next     = byte_cnt;
    vout_next    = 1'b0;
    sow_next     = 1'b0;
    dout_next    = dout_q;
    lane_next    = lane_q;
    emit         = 1'b0;
`ifdef ARB_TIMEOUT_EN
    stall_next   = '0;
`endif
    case (state)
      IDLE: begin
        if (any_req) begin
          grant_next = gnt_idx;
          state_next = BURST;
        end
      end
      BURST: begin
        if (bus.valid_lane[grant]) begin
          emit      = 1'b1;
          vout_next = 1'b1;
          dout_next = grant_byte;
          lane_next = grant;
          sow_next  = (byte_cnt == '0);
        end
`ifdef ARB_TIMEOUT_EN
        else if (byte_cnt != '0) begin
          if (stall_cnt == STALL_LIMIT) state_next = PAD;
          else                          stall_next = stall_cnt + 1'b1;
        end
`endif
      end
`ifdef ARB_TIMEOUT_EN
      PAD: begin
        emit      = 1'b1;
        vout_next = 1'b1;
        dout_next = PAD_BYTE;
        lane_next = grant;
      end
`endif
      default: state_next = IDLE;
    endcase

    if (emit) begin
      if (byte_cnt == LAST_BYTE) begin
        cnt_next     = '0;
        rr_last_next = grant;
        if (any_req) begin
          grant_next = gnt_idx;
          state_next = BURST;
        end else begin
          state_next = IDLE;
        end
      end else begin
        cnt_next = byte_cnt + 1'b1;
      end
    end
  end

  // State and output registers with synchronous reset; lane 0 wins first after reset.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      rr_last  <= IDXW'(N_LANES - 1);
      byte_cnt <= '0;
      vout_q   <= 1'b0;
      dout_q   <= '0;
      lane_q   <= '0;
      sow_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      stall_cnt <= '0;
`endif
    end else begin
      state    <= state_next;
      grant    <= grant_next;
      rr_last  <= rr_last_next;
      byte_cnt <= cnt_next;
      vout_q   <= vout_next;
      dout_q   <= dout_next;
      lane_q   <= lane_next;
      sow_q    <= sow_next;
`ifdef ARB_TIMEOUT_EN
      stall_cnt <= stall_next;
`endif
    end
  end

  assign bus.ready_lane = (state == BURST) ? (LANE0_HOT << grant) : '0;
  assign bus.valid_out  = vout_q;
  assign bus.Data_out   = dout_q;
  assign bus.lane_out   = lane_q;
  assign bus.sow_out    = sow_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_lane_word_arbiter.sv
// Self-checking bench for lane_word_arbiter: table vectors, hand sequences
// and randomized traffic against a word-level round-robin reference model.
// Optional feature macro: ARB_TIMEOUT_EN enables the padding sequence.
module tb_lane_word_arbiter;

  localparam int         N        = 4;
  localparam int         WB       = 4;
  localparam int         TIMEOUT  = 8;
  localparam logic [7:0] PAD_BYTE = 8'hBC;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk_4f = 1'b0;
  logic reset  = 1'b1;

  always #5 clk_4f = ~clk_4f;

  lane_word_arbiter_if #(.N_LANES(N)) bus ();

  lane_word_arbiter #(
    .N_LANES    (N),
    .WORD_BYTES (WB)
  ) dut (
    .clk_4f (clk_4f),
    .reset  (reset),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: which lane owns the current word, how full it is,
  // and which lane finished the previous word.
  int         m_owner = -1;
  int         m_filled = 0;
  int         m_prev = N - 1;
  int         m_stall = 0;
  bit         m_pad = 1'b0;
  logic       m_vo = 1'b0, m_sow = 1'b0;
  logic [7:0] m_dout = 8'h00;
  logic [1:0] m_lane = 2'd0;
  logic [3:0] m_ready_pre, dut_ready_pre;
  bit         ready_known = 1'b0, ready_known_pre;

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  ready;
    logic        vo;
    logic [7:0]  dout;
    logic [1:0]  lane;
    logic        sow;
    logic        busy;
  } vec_t;

  vec_t tbl[6];

  function automatic int rr_pick(input logic [3:0] req, input int last);
    for (int k = 1; k <= N; k++)
      if (req[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic model_edge(input logic [3:0] v, input logic [31:0] d, input logic r);
    bit emit;
    emit = 1'b0;
    if (r) begin
      m_owner = -1; m_filled = 0; m_prev = N - 1; m_stall = 0; m_pad = 1'b0;
      m_vo = 1'b0; m_sow = 1'b0; m_dout = 8'h00; m_lane = 2'd0;
      return;
    end
    m_vo  = 1'b0;
    m_sow = 1'b0;
    if (m_owner < 0) begin
      if (v != 4'd0) m_owner = rr_pick(v, m_prev);
    end else begin
      if (m_pad) begin
        emit = 1'b1;
        m_dout = PAD_BYTE;
      end else if (v[m_owner]) begin
        emit = 1'b1;
        m_dout = d[m_owner*8 +: 8];
        m_stall = 0;
      end else if (TO_EN && m_filled > 0) begin
        m_stall++;
        if (m_stall == TIMEOUT) m_pad = 1'b1;
      end
      if (emit) begin
        m_vo   = 1'b1;
        m_lane = 2'(m_owner);
        m_sow  = (m_filled == 0);
        m_filled++;
        if (m_filled == WB) begin
          m_filled = 0;
          m_prev   = m_owner;
          m_pad    = 1'b0;
          m_stall  = 0;
          m_owner  = (v != 4'd0) ? rr_pick(v, m_prev) : -1;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, sample ready before the edge, step the model at the edge.
  task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d, input logic r);
    @(negedge clk_4f);
    bus.valid_lane = v;
    bus.data_lane  = d;
    reset          = r;
    #1;
    dut_ready_pre   = bus.ready_lane;
    m_ready_pre     = (m_owner >= 0 && !m_pad) ? (4'b0001 << m_owner) : 4'b0000;
    ready_known_pre = ready_known;
    @(posedge clk_4f);
    model_edge(v, d, r);
    if (r) ready_known = 1'b1;
    #1;
  endtask

  task automatic checkOutput(input string tag);
    if (ready_known_pre) chk({tag, ".ready_lane"}, int'(dut_ready_pre), int'(m_ready_pre));
    chk({tag, ".valid_out"}, int'(bus.valid_out), int'(m_vo));
    chk({tag, ".Data_out"},  int'(bus.Data_out),  int'(m_dout));
    chk({tag, ".lane_out"},  int'(bus.lane_out),  int'(m_lane));
    chk({tag, ".sow_out"},   int'(bus.sow_out),   int'(m_sow));
    chk({tag, ".busy"},      int'(bus.busy),      int'(m_owner >= 0));
  endtask

  initial begin
    int         vo_count, low_count, pad_count;
    bit         seen;
    logic [31:0] word;
    logic [31:0] rd;
    logic [3:0]  rv;

    bus.valid_lane = '0;
    bus.data_lane  = '0;

    // Lane 2 alone sends 11,22,33,44; it is still requesting at word end so it keeps the grant.
    tbl[0] = '{4'b0100, 32'h0011_0000, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1};
    tbl[1] = '{4'b0100, 32'h0011_0000, 4'b0100, 1'b1, 8'h11, 2'd2, 1'b1, 1'b1};
    tbl[2] = '{4'b0100, 32'h0022_0000, 4'b0100, 1'b1, 8'h22, 2'd2, 1'b0, 1'b1};
    tbl[3] = '{4'b0100, 32'h0033_0000, 4'b0100, 1'b1, 8'h33, 2'd2, 1'b0, 1'b1};
    tbl[4] = '{4'b0100, 32'h0044_0000, 4'b0100, 1'b1, 8'h44, 2'd2, 1'b0, 1'b1};
    tbl[5] = '{4'b0000, 32'h0000_0000, 4'b0100, 1'b0, 8'h44, 2'd2, 1'b0, 1'b1};

    $display("[TB] reset held with all lanes valid");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'hF, $urandom, 1'b1);
      checkOutput("reset");
    end

    $display("[TB] table: single lane word");
    word = '0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(tbl[i].v, tbl[i].d, 1'b0);
      chk("tbl.ready_lane", int'(dut_ready_pre),  int'(tbl[i].ready));
      chk("tbl.valid_out",  int'(bus.valid_out),  int'(tbl[i].vo));
      chk("tbl.Data_out",   int'(bus.Data_out),   int'(tbl[i].dout));
      chk("tbl.lane_out",   int'(bus.lane_out),   int'(tbl[i].lane));
      chk("tbl.sow_out",    int'(bus.sow_out),    int'(tbl[i].sow));
      chk("tbl.busy",       int'(bus.busy),       int'(tbl[i].busy));
      if (bus.valid_out) word = {word[23:0], bus.Data_out};
    end
    chk("tbl.packed_word", int'(word), int'(32'h11223344));

    $display("[TB] all lanes valid: back-to-back words");
    applyStimulus(4'h0, 32'h0, 1'b1);
    checkOutput("rr.reset");
    vo_count = 0;
    for (int c = 0; c < 17; c++) begin
      applyStimulus(4'hF, $urandom, 1'b0);
      checkOutput("rr");
      if (c >= 1 && bus.valid_out) begin
        chk("rr.word_lane", int'(bus.lane_out), (vo_count / WB) % N);
        vo_count++;
      end
    end
    chk("rr.valid_count", vo_count, 16);

    $display("[TB] lane 1 stalls mid-word");
    applyStimulus(4'h0, 32'h0, 1'b1);
    checkOutput("stall.reset");
    vo_count = 0;
    low_count = 0;
    applyStimulus(4'b0010, 32'h0000_A000, 1'b0);
    checkOutput("stall");
    for (int c = 0; c < 6; c++) begin
      rv = (c == 2 || c == 3) ? 4'b0000 : 4'b0010;
      applyStimulus(rv, {16'h0, 8'hA1 + 8'(c), 8'h00}, 1'b0);
      checkOutput("stall");
      if (bus.valid_out) begin
        vo_count++;
        chk("stall.lane", int'(bus.lane_out), 1);
      end else begin
        low_count++;
      end
    end
    chk("stall.bytes", vo_count, 4);
    chk("stall.low_cycles", low_count, 2);

    $display("[TB] reset mid-word");
    applyStimulus(4'h0, 32'h0, 1'b1);
    applyStimulus(4'b1000, 32'h3300_0000, 1'b0);
    applyStimulus(4'b1000, 32'h3400_0000, 1'b0);
    checkOutput("midrst");
    applyStimulus(4'b1000, 32'h3500_0000, 1'b0);
    checkOutput("midrst");
    applyStimulus(4'b1000, 32'h3600_0000, 1'b1);
    checkOutput("midrst.reset");
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'hF, 32'h4433_2255, 1'b0);
      checkOutput("midrst.after");
      if (bus.valid_out && !seen) begin
        seen = 1'b1;
        chk("midrst.first_lane", int'(bus.lane_out), 0);
        chk("midrst.first_sow",  int'(bus.sow_out), 1);
        chk("midrst.first_data", int'(bus.Data_out), 8'h55);
      end
    end
    chk("midrst.seen_byte", int'(seen), 1);

`ifdef ARB_TIMEOUT_EN
    $display("[TB] timeout padding on lane 3");
    applyStimulus(4'h0, 32'h0, 1'b1);
    applyStimulus(4'b1000, 32'hA100_0000, 1'b0);
    checkOutput("pad");
    applyStimulus(4'b1000, 32'hA100_0000, 1'b0);
    checkOutput("pad");
    pad_count = 0;
    seen = 1'b0;
    for (int c = 0; c < 16; c++) begin
      applyStimulus(4'b0001, 32'h0000_00C0, 1'b0);
      checkOutput("pad");
      if (bus.valid_out && bus.Data_out == PAD_BYTE && bus.lane_out == 2'd3) pad_count++;
      if (bus.valid_out && bus.lane_out == 2'd0 && !seen) begin
        seen = 1'b1;
        chk("pad.next_sow", int'(bus.sow_out), 1);
      end
    end
    chk("pad.count", pad_count, 3);
    chk("pad.next_lane_granted", int'(seen), 1);
`endif

    $display("[TB] randomized traffic");
    applyStimulus(4'h0, 32'h0, 1'b1);
    checkOutput("rand.reset");
    for (int c = 0; c < 600; c++) begin
      for (int l = 0; l < N; l++) rv[l] = ($urandom_range(0, 9) < 6);
      rd = $urandom;
      applyStimulus(rv, rd, ($urandom_range(0, 199) == 0));
      checkOutput("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
